// File: rtl/ima_pkg.sv
// rtl/ima_pkg.sv - shared dimensions, offset widths, limits and FSM types for the mask offset manager
package ima_pkg;

  // Default image and mask geometry in pixels
  localparam int DEF_IMG_ROWS  = 240;
  localparam int DEF_IMG_COLS  = 320;
  localparam int DEF_MASK_ROWS = 120;
  localparam int DEF_MASK_COLS = 160;

  // Largest legal offsets that keep the mask fully inside the image
  localparam int ROW_MAX = DEF_IMG_ROWS - DEF_MASK_ROWS;
  localparam int COL_MAX = DEF_IMG_COLS - DEF_MASK_COLS;

  // Port widths
  localparam int ROW_W  = 8;
  localparam int COL_W  = 9;
  localparam int STEP_W = 4;
  localparam int MISS_W = 8;

  // Movement mode encoding on the mode input
  localparam logic MODE_AUTO   = 1'b0;
  localparam logic MODE_MANUAL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_UPDATE  = 2'd2
  } state_t;

  typedef enum logic {
    DIR_PLUS  = 1'b0,
    DIR_MINUS = 1'b1
  } dir_t;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [MISS_W-1:0] sat_inc(input logic [MISS_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/offset_axis.sv
// rtl/offset_axis.sv - one offset axis: step, clamp, auto bounce and direction register
//
// Ports:
//   clk, rst  : clock and synchronous active-high reset (offset 0, direction plus)
//   load      : commit the computed next offset/direction at this clock edge
//   mode      : 0 = auto bounce, 1 = manual buttons (only matters while load is high)
//   step      : pixels moved per update, 0 = hold
//   inc, dec  : manual buttons towards larger / smaller offset
//   offset    : registered offset, always within 0..MAX
module offset_axis
  import ima_pkg::*;
#(
  parameter int W   = ROW_W,
  parameter int MAX = ROW_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              mode,
  input  logic [STEP_W-1:0] step,
  input  logic              inc,
  input  logic              dec,
  output logic [W-1:0]      offset
);

  // Two extra bits: one for the carry past MAX, one for the sign on underflow,
  // so both limits are seen before the value is clamped back into range.
  localparam int AW = W + 2;
  localparam logic signed [AW-1:0] MAX_S  = AW'(MAX);
  localparam logic signed [AW-1:0] ZERO_S = '0;

  dir_t                 dir;
  dir_t                 dir_next;
  logic [W-1:0]         offset_next;
  logic signed [AW-1:0] cur_s;
  logic signed [AW-1:0] step_s;
  logic signed [AW-1:0] sum_s;
  logic signed [AW-1:0] diff_s;
  logic signed [AW-1:0] target_s;

  assign cur_s  = signed'({2'b00, offset});
  assign step_s = signed'(AW'(step));
  assign sum_s  = cur_s + step_s;
  assign diff_s = cur_s - step_s;

  always_comb begin
    offset_next = offset;
    dir_next    = dir;
    target_s    = cur_s;
    if (mode == MODE_AUTO) begin
      // A zero step must not flip the direction when sitting on a limit.
      if (step != '0) begin
        target_s = (dir == DIR_MINUS) ? diff_s : sum_s;
        if (target_s >= MAX_S) begin
          offset_next = W'(MAX);
          dir_next    = DIR_MINUS;
        end else if (target_s <= ZERO_S) begin
          offset_next = '0;
          dir_next    = DIR_PLUS;
        end else begin
          offset_next = target_s[W-1:0];
        end
      end
    end else begin
      // Both buttons of a pair held cancel out; direction is left alone
      // so auto mode resumes the way it was heading.
      if (inc && !dec) begin
        target_s = sum_s;
      end else if (dec && !inc) begin
        target_s = diff_s;
      end
      if (target_s >= MAX_S) begin
        offset_next = W'(MAX);
      end else if (target_s < ZERO_S) begin
        offset_next = '0;
      end else begin
        offset_next = target_s[W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      offset <= '0;
      dir    <= DIR_PLUS;
    end else if (load) begin
      offset <= offset_next;
      dir    <= dir_next;
    end
  end

endmodule

// File: rtl/mask_offset_manager.sv
// rtl/mask_offset_manager.sv - frame-synchronous row/col offset manager for the masking unit
//
// Ports:
//   clk, rst          : clock and synchronous active-high reset
//   frame_start       : one-cycle pulse marking a new display frame
//   xfer_busy         : transfer/masking pipeline mid-frame, offsets must hold
//   enable            : 0 = freeze offsets and ignore frame_start
//   mode              : 0 = auto bounce, 1 = manual buttons
//   btn_up/down       : manual row decrement / increment
//   btn_left/right    : manual col decrement / increment
//   step              : pixels per update, 0 = hold
//   mask_row_offset   : registered row offset, 0..IMG_ROWS-MASK_ROWS
//   mask_col_offset   : registered col offset, 0..IMG_COLS-MASK_COLS
//   offset_valid      : one-cycle pulse the cycle after each update
//   missed_frames     : saturating count of frame_start pulses that were coalesced
module mask_offset_manager
  import ima_pkg::*;
#(
  parameter int IMG_ROWS  = DEF_IMG_ROWS,
  parameter int IMG_COLS  = DEF_IMG_COLS,
  parameter int MASK_ROWS = DEF_MASK_ROWS,
  parameter int MASK_COLS = DEF_MASK_COLS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              xfer_busy,
  input  logic              enable,
  input  logic              mode,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_left,
  input  logic              btn_right,
  input  logic [STEP_W-1:0] step,
  output logic [ROW_W-1:0]  mask_row_offset,
  output logic [COL_W-1:0]  mask_col_offset,
  output logic              offset_valid,
  output logic [MISS_W-1:0] missed_frames
);

  localparam int ROW_LIM = IMG_ROWS - MASK_ROWS;
  localparam int COL_LIM = IMG_COLS - MASK_COLS;

  state_t state;
  logic   axis_load;

  // Offsets commit on the edge that leaves UPDATE; step and mode are
  // therefore only looked at during that single cycle.
  assign axis_load = (state == ST_UPDATE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      offset_valid  <= 1'b0;
      missed_frames <= '0;
    end else begin
      offset_valid <= 1'b0;

      // A frame arriving while one is already queued or being applied is
      // folded into that update rather than scheduling another.
      if (frame_start && (state != ST_IDLE)) begin
        missed_frames <= sat_inc(missed_frames);
      end

      case (state)
        ST_IDLE: begin
          if (frame_start && enable) begin
            state <= xfer_busy ? ST_PENDING : ST_UPDATE;
          end
        end
        ST_PENDING: begin
          if (!enable) begin
            state <= ST_IDLE;
          end else if (!xfer_busy) begin
            state <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          state        <= ST_IDLE;
          offset_valid <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  offset_axis #(
    .W   (ROW_W),
    .MAX (ROW_LIM)
  ) u_row_axis (
    .clk    (clk),
    .rst    (rst),
    .load   (axis_load),
    .mode   (mode),
    .step   (step),
    .inc    (btn_down),
    .dec    (btn_up),
    .offset (mask_row_offset)
  );

  offset_axis #(
    .W   (COL_W),
    .MAX (COL_LIM)
  ) u_col_axis (
    .clk    (clk),
    .rst    (rst),
    .load   (axis_load),
    .mode   (mode),
    .step   (step),
    .inc    (btn_right),
    .dec    (btn_left),
    .offset (mask_col_offset)
  );

endmodule

// File: tb/tb_mask_offset_manager.sv
// tb/tb_mask_offset_manager.sv - self-checking bench for mask_offset_manager
module tb_mask_offset_manager;

  localparam int ROW_MAX = 120;
  localparam int COL_MAX = 160;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_start;
  logic       xfer_busy;
  logic       enable;
  logic       mode;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic [3:0] step;
  logic [7:0] mask_row_offset;
  logic [8:0] mask_col_offset;
  logic       offset_valid;
  logic [7:0] missed_frames;

  int n_pass  = 0;
  int n_total = 0;

  // Reference state: offsets, direction as +1/-1, missed count
  int m_row, m_col, m_rdir, m_cdir, m_miss;

  mask_offset_manager dut (
    .clk             (clk),
    .rst             (rst),
    .frame_start     (frame_start),
    .xfer_busy       (xfer_busy),
    .enable          (enable),
    .mode            (mode),
    .btn_up          (btn_up),
    .btn_down        (btn_down),
    .btn_left        (btn_left),
    .btn_right       (btn_right),
    .step            (step),
    .mask_row_offset (mask_row_offset),
    .mask_col_offset (mask_col_offset),
    .offset_valid    (offset_valid),
    .missed_frames   (missed_frames)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
  endtask

  function automatic int sat_miss(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  // One axis update from the rules: auto bounces between 0 and mx,
  // manual moves by +/-step and clamps.
  function automatic void axis_model(input int mx, input bit manual, input int st,
                                     input bit inc, input bit dec,
                                     inout int off, inout int dir);
    int r;
    if (!manual) begin
      if (st == 0) return;
      r = off + dir * st;
      if (r >= mx) begin
        off = mx;
        dir = -1;
      end else if (r <= 0) begin
        off = 0;
        dir = 1;
      end else begin
        off = r;
      end
    end else begin
      r = off;
      if (inc && !dec) r = off + st;
      else if (dec && !inc) r = off - st;
      off = (r > mx) ? mx : ((r < 0) ? 0 : r);
    end
  endfunction

  task automatic model_reset();
    m_row  = 0;
    m_col  = 0;
    m_rdir = 1;
    m_cdir = 1;
    m_miss = 0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_row"}, mask_row_offset, m_row);
    check({tag, "_col"}, mask_col_offset, m_col);
    check({tag, "_miss"}, missed_frames, m_miss);
  endtask

  // Full frame: request, optional busy stretch, UPDATE cycle, result.
  // step/mode carry junk outside the UPDATE cycle to show they are ignored there.
  task automatic frame(input bit m, input int st, input bit up, input bit dn,
                       input bit lf, input bit rt, input int busy_cycles, input bit fs_upd);
    btn_up      = up;
    btn_down    = dn;
    btn_left    = lf;
    btn_right   = rt;
    enable      = 1'b1;
    mode        = ~m;
    step        = 4'($urandom_range(0, 15));
    xfer_busy   = (busy_cycles > 0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    if (busy_cycles > 0) begin
      for (int i = 0; i < busy_cycles - 1; i++) begin
        frame_start = 1'($urandom_range(0, 1));
        if (frame_start) m_miss = sat_miss(m_miss);
        tick();
        check("busy_valid", offset_valid, 0);
      end
      frame_start = 1'b0;
      xfer_busy   = 1'b0;
      tick();
    end
    mode        = m;
    step        = 4'(st);
    frame_start = fs_upd;
    if (fs_upd) m_miss = sat_miss(m_miss);
    check("upd_hold_row", mask_row_offset, m_row);
    check("upd_valid", offset_valid, 0);
    tick();
    frame_start = 1'b0;
    axis_model(ROW_MAX, m, st, dn, up, m_row, m_rdir);
    axis_model(COL_MAX, m, st, rt, lf, m_col, m_cdir);
    check("post_valid", offset_valid, 1);
    check_state("post");
    mode = ~m;
    step = 4'($urandom_range(0, 15));
    tick();
    check("pulse_end", offset_valid, 0);
    check("after_row", mask_row_offset, m_row);
    check("after_col", mask_col_offset, m_col);
  endtask

  initial begin
    int col_before;
    bit saw_valid;

    rst = 1'b1; frame_start = 1'b0; xfer_busy = 1'b0; enable = 1'b0; mode = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0; step = 4'd0;
    model_reset();
    tick();
    tick();
    check("rst_valid", offset_valid, 0);
    check_state("rst");
    rst = 1'b0;

    // First auto update lands two cycles after frame_start
    frame(1'b0, 4, 0, 0, 0, 0, 0, 1'b0);
    check("first_row4", mask_row_offset, 4);
    check("first_col4", mask_col_offset, 4);

    // Walk manually to 118 (directions stay plus), then bounce at the row limit
    for (int i = 0; i < 7; i++) frame(1'b1, 15, 0, 1, 0, 1, 0, 1'b0);
    frame(1'b1, 9, 0, 1, 0, 1, 0, 1'b0);
    check("row118", mask_row_offset, 118);
    frame(1'b0, 4, 0, 0, 0, 0, 0, 1'b0);
    check("row_hits_max", mask_row_offset, ROW_MAX);
    frame(1'b0, 4, 0, 0, 0, 0, 0, 1'b0);
    check("row_bounced", mask_row_offset, 116);
    for (int i = 0; i < 20 && m_col != COL_MAX; i++) frame(1'b0, 4, 0, 0, 0, 0, 0, 1'b0);
    check("col_hits_max", mask_col_offset, COL_MAX);
    frame(1'b0, 4, 0, 0, 0, 0, 0, 1'b0);
    check("col_bounced", mask_col_offset, 156);
    frame(1'b0, 0, 0, 0, 0, 0, 0, 1'b0);
    check("step0_hold", mask_col_offset, 156);

    // Manual clamping and cancelling buttons
    for (int i = 0; i < 9; i++) frame(1'b1, 15, 1, 0, 0, 0, 0, 1'b0);
    frame(1'b1, 1, 0, 1, 0, 0, 0, 1'b0);
    frame(1'b1, 3, 1, 0, 0, 0, 0, 1'b0);
    check("man_row_floor", mask_row_offset, 0);
    col_before = m_col;
    frame(1'b1, 3, 0, 0, 1, 1, 0, 1'b0);
    check("man_lr_cancel", mask_col_offset, col_before);
    for (int i = 0; i < 8; i++) frame(1'b1, 15, 0, 1, 0, 0, 0, 1'b0);
    frame(1'b1, 1, 1, 0, 0, 0, 0, 1'b0);
    frame(1'b1, 3, 0, 1, 0, 0, 0, 1'b0);
    check("man_row_ceil", mask_row_offset, ROW_MAX);

    // Long busy stretch with two extra frames: one update, two misses
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    enable = 1'b1; xfer_busy = 1'b1; mode = 1'b0; step = 4'd4;
    frame_start = 1'b1;
    tick();
    saw_valid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      frame_start = (i == 10 || i == 30);
      tick();
      if (offset_valid) saw_valid = 1'b1;
    end
    frame_start = 1'b0;
    m_miss = sat_miss(sat_miss(m_miss));
    check("busy_no_valid", saw_valid, 0);
    check_state("busy_hold");
    xfer_busy = 1'b0;
    tick();
    tick();
    axis_model(ROW_MAX, 1'b0, 4, 0, 0, m_row, m_rdir);
    axis_model(COL_MAX, 1'b0, 4, 0, 0, m_col, m_cdir);
    check("busy_done_valid", offset_valid, 1);
    check_state("busy_done");
    check("missed_two", missed_frames, 2);
    tick();

    // Saturation: 300 pulses while pending
    xfer_busy = 1'b1;
    frame_start = 1'b1;
    tick();
    for (int i = 0; i < 300; i++) begin
      tick();
      m_miss = sat_miss(m_miss);
    end
    frame_start = 1'b0;
    check("missed_sat", missed_frames, 255);
    check("missed_model", missed_frames, m_miss);

    // Dropping enable while pending abandons the update
    enable = 1'b0;
    tick();
    xfer_busy = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (offset_valid) saw_valid = 1'b1;
    end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (offset_valid) saw_valid = 1'b1;
    end
    check("disabled_no_valid", saw_valid, 0);
    check_state("disabled_hold");

    // Reset in the middle of UPDATE wins over the update
    enable = 1'b1; mode = 1'b1; step = 4'd5; btn_up = 1'b1; btn_left = 1'b1;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    btn_up = 1'b0; btn_left = 1'b0;
    model_reset();
    check("midrst_valid", offset_valid, 0);
    check_state("midrst");
    tick();
    check("midrst_no_pulse", offset_valid, 0);

    // Random frames against the reference model
    for (int n = 0; n < 60; n++) begin
      frame(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 4)), ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
